i2c_slave_rx: RTL and testbench
===============================

I2C_SLAVE_RX -- requirements
Module: i2c_slave_rx

Interface
REQ-001 Parameter SLAVE_ADDR, default 7'h50, 7-bit address this slave acknowledges.
REQ-002 gclk  input  1  single system clock; all logic on its rising edge.
REQ-003 rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 sck_fall, sck_rise, sck_high, sck_low  input  1 each  SCK strobes from the upstream edge-conditioning stage, at most one asserted per cycle.
REQ-005 sda_fall, sda_rise, sda_high, sda_low  input  1 each  SDA strobes from the upstream stage, at most one asserted per cycle.
REQ-006 sda_drive_low  output  1  when 1, top level pulls the open-drain SDA pin low; when 0, SDA is released.
REQ-007 rx_data  output  8  last received data byte, MSB first on the wire.
REQ-008 rx_valid  output  1  one-cycle pulse; rx_data is newly valid.
REQ-009 rx_start, rx_stop  output  1 each  one-cycle pulses on detected START/repeated START and STOP.
REQ-010 rx_byte_cnt  output  8  data bytes received in the current transaction, saturating at 8'hFF.
REQ-011 busy  output  1  high from START to STOP.

Function
REQ-012 START = sda_fall && sck_high; STOP = sda_rise && sck_high; each SHALL pulse rx_start/rx_stop in the following cycle.
REQ-013 An internal sda_level register SHALL be set by sda_high, cleared by sda_low, held otherwise; data bits are sampled from sda_level on sck_rise.
REQ-014 States: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
REQ-015 IDLE: ignore all sck strobes; START -> ADDR, bit counter = 0, rx_byte_cnt = 0.
REQ-016 ADDR: shift in 8 bits on sck_rise (7 address + R/W); after 8th bit, if address == SLAVE_ADDR and R/W == 0 -> ADDR_ACK, else -> IGNORE.
REQ-017 ADDR_ACK / DATA_ACK: assert sda_drive_low on the first sck_fall after entry; hold through the ACK sck_rise; release on the next sck_fall, then -> DATA with bit counter = 0.
REQ-018 DATA: shift in 8 bits on sck_rise; on the 8th, rx_data updates and rx_valid pulses in the next cycle, rx_byte_cnt increments (saturating), state -> DATA_ACK.
REQ-019 IGNORE: never drive SDA; remain until START or STOP.
REQ-020 START in any state (repeated START) SHALL restart ADDR: bit counter = 0, sda_drive_low = 0, rx_byte_cnt = 0.
REQ-021 STOP in any state SHALL go to IDLE and release sda_drive_low the same edge; a partial byte is discarded, no rx_valid.
REQ-022 START/STOP take priority over sck_rise/sck_fall in the same cycle.
REQ-023 sda_drive_low SHALL only change on an sck_fall cycle, except release on START/STOP/reset.
REQ-024 busy = 1 in every state except IDLE.

Reset
REQ-025 On rst: state IDLE, sda_drive_low 0, rx_data 8'h00, rx_valid 0, rx_start 0, rx_stop 0, rx_byte_cnt 0, busy 0, sda_level 1, bit counter 0.
REQ-026 rst asserted mid-transaction SHALL release SDA in the next cycle and ignore all strobes until the next START after deassertion.

Structure
REQ-027 State encoding, SLAVE_ADDR default and bit-count width SHALL live in a shared i2c definitions package/include used by all I2C blocks.
REQ-028 No sub-module; the edge-conditioning stage is instantiated beside this block at top level, not inside it.

Verification
REQ-029 START, addr 0x50+W, data 0xA5, STOP -> sda_drive_low during both ACK clocks, rx_data=0xA5 with one rx_valid pulse, rx_byte_cnt=1, busy back to 0.
REQ-030 Address 0x51+W -> no ACK, state IGNORE, no rx_valid, next START with 0x50 accepted normally.
REQ-031 Address 0x50+R -> NACK (sda_drive_low stays 0), IGNORE until STOP.
REQ-032 Three bytes 0x01,0x02,0x03, repeated START mid-4th byte, 0x50+W, 0x7E -> three rx_valid pulses, rx_byte_cnt reset to 0 then 1, rx_data=0x7E.
REQ-033 STOP after 5 data bits -> no rx_valid, rx_data unchanged, IDLE, SDA released.
REQ-034 rst during DATA_ACK with sda_drive_low=1 -> sda_drive_low=0 next cycle, all outputs at reset values.

Source files
------------

// File: rtl/i2c_slave_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module : i2c_slave_rx_pkg
// Brief  : Shared I2C definitions: slave FSM encoding, default address, bit-count width.
// Rev    : 1.0
// ============================================================================
package i2c_slave_rx_pkg;

  localparam logic [6:0]  I2C_SLAVE_ADDR_DEFAULT = 7'h50;
  localparam int unsigned I2C_BIT_CNT_W          = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_DATA     = 3'd3,
    ST_DATA_ACK = 3'd4,
    ST_IGNORE   = 3'd5
  } i2c_state_e;

endpackage
`default_nettype wire

// File: rtl/i2c_slave_rx.sv
`default_nettype none
// ============================================================================
// Module : i2c_slave_rx
// Brief  : Write-only I2C slave receiver driven by pre-conditioned SCK/SDA strobes.
// Rev    : 1.0
// ============================================================================
module i2c_slave_rx
  import i2c_slave_rx_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = I2C_SLAVE_ADDR_DEFAULT
) (
  input  logic       gclk,
  input  logic       rst,
  input  logic       sck_fall,
  input  logic       sck_rise,
  input  logic       sck_high,
  input  logic       sck_low,
  input  logic       sda_fall,
  input  logic       sda_rise,
  input  logic       sda_high,
  input  logic       sda_low,
  output logic       sda_drive_low,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_start,
  output logic       rx_stop,
  output logic [7:0] rx_byte_cnt,
  output logic       busy
);

  localparam logic [I2C_BIT_CNT_W-1:0] BIT_LAST = '1;

  i2c_state_e                 state_q, state_d;
  logic [I2C_BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [7:0]                 shift_q, shift_d;
  logic                       sda_level_q, sda_level_d;
  logic                       sda_drive_q, sda_drive_d;
  logic [7:0]                 rx_data_q, rx_data_d;
  logic                       rx_valid_q, rx_valid_d;
  logic                       rx_start_q, rx_start_d;
  logic                       rx_stop_q, rx_stop_d;
  logic [7:0]                 byte_cnt_q, byte_cnt_d;

  logic       w_start;
  logic       w_stop;
  logic [7:0] w_byte;
  logic       w_unused;

  assign w_start  = sda_fall && sck_high;
  assign w_stop   = sda_rise && sck_high;
  assign w_byte   = {shift_q[6:0], sda_level_q};
  assign w_unused = sck_low;

  always_ff @(posedge gclk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= 8'h00;
      sda_level_q <= 1'b1;
      sda_drive_q <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      rx_start_q  <= 1'b0;
      rx_stop_q   <= 1'b0;
      byte_cnt_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      sda_level_q <= sda_level_d;
      sda_drive_q <= sda_drive_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_start_q  <= rx_start_d;
      rx_stop_q   <= rx_stop_d;
      byte_cnt_q  <= byte_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    sda_level_d = sda_level_q;
    sda_drive_d = sda_drive_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    rx_start_d  = w_start;
    rx_stop_d   = w_stop;
    byte_cnt_d  = byte_cnt_q;

    if (sda_high) begin
      sda_level_d = 1'b1;
    end else if (sda_low) begin
      sda_level_d = 1'b0;
    end

    // Bus conditions pre-empt any clock activity seen in the same cycle.
    if (w_stop) begin
      state_d     = ST_IDLE;
      bit_cnt_d   = '0;
      sda_drive_d = 1'b0;
    end else if (w_start) begin
      state_d     = ST_ADDR;
      bit_cnt_d   = '0;
      sda_drive_d = 1'b0;
      byte_cnt_d  = 8'h00;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (sck_rise) begin
            shift_d = w_byte;
            if (bit_cnt_q == BIT_LAST) begin
              bit_cnt_d = '0;
              state_d   = ((w_byte[7:1] == SLAVE_ADDR) && !w_byte[0]) ? ST_ADDR_ACK : ST_IGNORE;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
        // The drive flag doubles as the ACK phase: first fall pulls low, second releases.
        ST_ADDR_ACK, ST_DATA_ACK: begin
          if (sck_fall) begin
            if (!sda_drive_q) begin
              sda_drive_d = 1'b1;
            end else begin
              sda_drive_d = 1'b0;
              state_d     = ST_DATA;
              bit_cnt_d   = '0;
            end
          end
        end
        ST_DATA: begin
          if (sck_rise) begin
            shift_d = w_byte;
            if (bit_cnt_q == BIT_LAST) begin
              bit_cnt_d  = '0;
              rx_data_d  = w_byte;
              rx_valid_d = 1'b1;
              state_d    = ST_DATA_ACK;
              if (byte_cnt_q != 8'hFF) begin
                byte_cnt_d = byte_cnt_q + 8'd1;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign sda_drive_low = sda_drive_q;
  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_start      = rx_start_q;
  assign rx_stop       = rx_stop_q;
  assign rx_byte_cnt   = byte_cnt_q;
  assign busy          = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : tb_i2c_slave_rx
// Brief  : Directed bench for i2c_slave_rx with a received-byte scoreboard.
// Rev    : 1.0
// ============================================================================
module tb_i2c_slave_rx;

  logic       gclk = 1'b0;
  logic       rst  = 1'b1;
  logic       sck_fall = 1'b0, sck_rise = 1'b0, sck_high = 1'b1, sck_low = 1'b0;
  logic       sda_fall = 1'b0, sda_rise = 1'b0, sda_high = 1'b1, sda_low = 1'b0;
  logic       sda_drive_low;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_start;
  logic       rx_stop;
  logic [7:0] rx_byte_cnt;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int n_start = 0, n_stop = 0;
  int exp_start = 0, exp_stop = 0;
  logic [7:0] exp_q[$];
  logic cur_sck = 1'b1;
  logic cur_sda = 1'b1;

  i2c_slave_rx #(.SLAVE_ADDR(7'h50)) dut (
    .gclk          (gclk),
    .rst           (rst),
    .sck_fall      (sck_fall),
    .sck_rise      (sck_rise),
    .sck_high      (sck_high),
    .sck_low       (sck_low),
    .sda_fall      (sda_fall),
    .sda_rise      (sda_rise),
    .sda_high      (sda_high),
    .sda_low       (sda_low),
    .sda_drive_low (sda_drive_low),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_start      (rx_start),
    .rx_stop       (rx_stop),
    .rx_byte_cnt   (rx_byte_cnt),
    .busy          (busy)
  );

  always #5 gclk = ~gclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer and START/STOP pulse counters.
  always @(negedge gclk) begin
    if (rx_start) n_start++;
    if (rx_stop)  n_stop++;
    if (rx_valid) begin
      chk("sb_pending_on_rx_valid", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  // Move the lines: one cycle of edge strobes, then 'hold' cycles of level strobes.
  task automatic step(input logic nsck, input logic nsda, input int hold);
    sck_rise = nsck & ~cur_sck;  sck_fall = ~nsck & cur_sck;
    sck_high = nsck & cur_sck;   sck_low  = ~nsck & ~cur_sck;
    sda_rise = nsda & ~cur_sda;  sda_fall = ~nsda & cur_sda;
    sda_high = nsda & cur_sda;   sda_low  = ~nsda & ~cur_sda;
    cur_sck = nsck;
    cur_sda = nsda;
    tick();
    sck_rise = 1'b0; sck_fall = 1'b0; sck_high = nsck; sck_low = ~nsck;
    sda_rise = 1'b0; sda_fall = 1'b0; sda_high = nsda; sda_low = ~nsda;
    repeat (hold) tick();
  endtask

  task automatic bus_start();
    if (!cur_sck) begin
      step(1'b0, 1'b1, 1);
      step(1'b1, 1'b1, 1);
    end
    step(1'b1, 1'b0, 1);
    exp_start++;
    step(1'b0, 1'b0, 1);
  endtask

  task automatic bus_stop();
    if (cur_sck) step(1'b0, cur_sda, 1);
    step(1'b0, 1'b0, 1);
    step(1'b1, 1'b0, 1);
    step(1'b1, 1'b1, 1);
    exp_stop++;
    step(1'b1, 1'b1, 1);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, b[7-i], 1);
      step(1'b1, b[7-i], 1);
      step(1'b0, b[7-i], 1);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ack);
    send_bits(b, 8);
    chk("ack_after_fall", 32'(sda_drive_low), 32'(ack));
    step(1'b0, 1'b1, 1);
    step(1'b1, 1'b1, 1);
    chk("ack_during_high", 32'(sda_drive_low), 32'(ack));
    step(1'b0, 1'b1, 1);
    chk("ack_released", 32'(sda_drive_low), 32'd0);
  endtask

  task automatic check_idle_outputs(input logic [7:0] data, input logic [7:0] cnt);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_drive", 32'(sda_drive_low), 32'd0);
    chk("idle_rx_data", 32'(rx_data), 32'(data));
    chk("idle_byte_cnt", 32'(rx_byte_cnt), 32'(cnt));
  endtask

  initial begin
    // Reset values
    repeat (3) tick();
    chk("rst_drive", 32'(sda_drive_low), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_start", 32'(rx_start), 32'd0);
    chk("rst_rx_stop", 32'(rx_stop), 32'd0);
    chk("rst_byte_cnt", 32'(rx_byte_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    // Basic write: 0x50+W, 0xA5
    bus_start();
    chk("busy_after_start", 32'(busy), 32'd1);
    send_byte(8'hA0, 1'b1);
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1);
    chk("cnt_one", 32'(rx_byte_cnt), 32'd1);
    bus_stop();
    check_idle_outputs(8'hA5, 8'd1);

    // Wrong address is ignored; following transaction to 0x50 accepted
    bus_start();
    send_byte(8'hA2, 1'b0);
    send_byte(8'h33, 1'b0);
    chk("ignore_busy", 32'(busy), 32'd1);
    bus_start();
    send_byte(8'hA0, 1'b1);
    exp_q.push_back(8'h5A);
    send_byte(8'h5A, 1'b1);
    bus_stop();
    check_idle_outputs(8'h5A, 8'd1);

    // Read request is NACKed and ignored until STOP
    bus_start();
    send_byte(8'hA1, 1'b0);
    send_byte(8'hC3, 1'b0);
    chk("read_ignore_busy", 32'(busy), 32'd1);
    bus_stop();
    check_idle_outputs(8'h5A, 8'd0);

    // Three bytes, repeated START mid fourth byte, then 0x7E
    bus_start();
    send_byte(8'hA0, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      exp_q.push_back(8'(i));
      send_byte(8'(i), 1'b1);
    end
    chk("cnt_three", 32'(rx_byte_cnt), 32'd3);
    send_bits(8'hF0, 4);
    bus_start();
    chk("cnt_cleared_on_rstart", 32'(rx_byte_cnt), 32'd0);
    send_byte(8'hA0, 1'b1);
    exp_q.push_back(8'h7E);
    send_byte(8'h7E, 1'b1);
    chk("cnt_after_rstart", 32'(rx_byte_cnt), 32'd1);
    bus_stop();
    check_idle_outputs(8'h7E, 8'd1);

    // STOP after five data bits discards the partial byte
    bus_start();
    send_byte(8'hA0, 1'b1);
    send_bits(8'h00, 5);
    bus_stop();
    check_idle_outputs(8'h7E, 8'd0);

    // Reset while the slave is holding the data ACK
    bus_start();
    send_byte(8'hA0, 1'b1);
    exp_q.push_back(8'h11);
    send_bits(8'h11, 8);
    chk("ack_held_before_rst", 32'(sda_drive_low), 32'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_drive", 32'(sda_drive_low), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rx_data", 32'(rx_data), 32'd0);
    chk("mid_rst_byte_cnt", 32'(rx_byte_cnt), 32'd0);
    chk("mid_rst_rx_valid", 32'(rx_valid), 32'd0);
    rst = 1'b0;
    step(1'b0, 1'b1, 1);
    step(1'b1, 1'b1, 1);
    step(1'b0, 1'b1, 1);
    send_bits(8'hA0, 8);
    chk("post_rst_ignored_busy", 32'(busy), 32'd0);
    chk("post_rst_ignored_drive", 32'(sda_drive_low), 32'd0);
    bus_start();
    send_byte(8'hA0, 1'b1);
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b1);
    bus_stop();
    check_idle_outputs(8'h3C, 8'd1);

    // Byte counter saturates at 0xFF
    bus_start();
    send_byte(8'hA0, 1'b1);
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back(8'(i ^ 8'h5C));
      send_byte(8'(i ^ 8'h5C), 1'b1);
    end
    chk("cnt_saturated", 32'(rx_byte_cnt), 32'hFF);
    bus_stop();
    check_idle_outputs(8'(255 ^ 8'h5C), 8'hFF);

    repeat (3) tick();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    chk("start_pulses", 32'(n_start), 32'(exp_start));
    chk("stop_pulses", 32'(n_stop), 32'(exp_stop));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
